// File: rtl/time_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper
//  Description : BCD hours/minutes/seconds clock advanced by a slow, fully
//                asynchronous seconds clock (slowClk). slowClk is brought
//                into the clk domain through a SYNC_STAGES-deep flop chain.
//                A rising-edge detector on the synchronized level produces a
//                registered one-cycle tick, and each tick advances the time
//                by one second. A one-cycle load request replaces hours and
//                minutes and clears seconds. A load that fails validation
//                leaves the time unchanged and pulses load_err.
//
//  Optional    : define TWELVE_HOUR_EN for 12-hour mode. Hours run 01..12
//                and a pm output is added. Without the macro, hours run
//                00..23 and there is no pm port.
//
//  Parameters  : SYNC_STAGES  synchronizer depth on slowClk (legal 2..4)
//
//  Ports       : clk       in   system clock, rising-edge active
//                reset     in   asynchronous, active-high reset
//                slowClk   in   seconds clock, asynchronous to clk
//                load      in   one-cycle load request
//                load_hr   in   [7:0] BCD hours to load
//                load_min  in   [7:0] BCD minutes to load
//                sec       out  [7:0] BCD seconds 00..59
//                min       out  [7:0] BCD minutes 00..59
//                hr        out  [7:0] BCD hours
//                tick      out  one-cycle pulse per slowClk rising edge
//                load_err  out  one-cycle pulse when a load is rejected
//                pm        out  PM flag (TWELVE_HOUR_EN only)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module time_keeper #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slowClk,
    input  logic       load,
    input  logic [7:0] load_hr,
    input  logic [7:0] load_min,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hr,
    output logic       tick,
`ifdef TWELVE_HOUR_EN
    output logic       load_err,
    output logic       pm
`else
    output logic       load_err
`endif
);

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] RESET_HR = 8'h12;
`else
    localparam logic [7:0] RESET_HR = 8'h00;
`endif

    // ------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------

    // Seconds/minutes increment, 59 wraps to 00.
    function automatic logic [7:0] inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                r = 8'h00;
            else
                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

`ifdef TWELVE_HOUR_EN
    // 12-hour increment: 12 wraps to 01, 09 carries to 10.
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h12)
            r = 8'h01;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        return ((v[7:4] == 4'd0) && (v[3:0] >= 4'd1) && (v[3:0] <= 4'd9)) ||
               ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2));
    endfunction
`else
    // 24-hour increment: 23 wraps to 00.
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        return (v[3:0] <= 4'd9) &&
               ((v[7:4] < 4'd2) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
    endfunction
`endif

    function automatic logic minute_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    // ------------------------------------------------------------------
    // slowClk synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;
    logic                   synced;

    assign synced = sync_chain[SYNC_STAGES-1];

    // prev resets to 0 so that a slowClk held high across reset release
    // still yields exactly one tick once the level reaches the chain end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
            prev       <= 1'b0;
            tick       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], slowClk};
            prev       <= synced;
            tick       <= synced & ~prev;
        end
    end

    // ------------------------------------------------------------------
    // Time datapath
    // ------------------------------------------------------------------
    logic       load_ok;
    logic       sec_wrap;
    logic       min_wrap;
    logic [7:0] sec_next;
    logic [7:0] min_next;
    logic [7:0] hr_next;

    assign load_ok  = minute_ok(load_min) && hour_ok(load_hr);
    assign sec_wrap = (sec == 8'h59);
    // Minutes only roll over together with a seconds wrap, so a full
    // carry updates all three fields in the same clock.
    assign min_wrap = sec_wrap && (min == 8'h59);
    assign sec_next = inc_sixty(sec);
    assign min_next = inc_sixty(min);
    assign hr_next  = inc_hour(hr);

    // A load wins over a tick seen in the same cycle; that second is
    // dropped rather than applied later. The tick output itself is
    // generated independently and is not affected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec      <= 8'h00;
            min      <= 8'h00;
            hr       <= RESET_HR;
            load_err <= 1'b0;
`ifdef TWELVE_HOUR_EN
            pm       <= 1'b0;
`endif
        end else begin
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    hr  <= load_hr;
                    min <= load_min;
                    sec <= 8'h00;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (tick) begin
                sec <= sec_next;
                if (sec_wrap)
                    min <= min_next;
                if (min_wrap) begin
                    hr <= hr_next;
`ifdef TWELVE_HOUR_EN
                    // 11:59:59 -> 12:00:00 crosses noon/midnight.
                    if (hr == 8'h11)
                        pm <= ~pm;
`endif
                end
            end
        end
    end

endmodule
`default_nettype wire
